// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle slave with word-addressed internal memory and programmable wait states.
// Define WB_SLAVE_MEM_RTY_EN to compile in periodic retry (rty_o) injection.
module wb_slave_mem #(
    parameter int unsigned   DW          = 32,
    parameter int unsigned   AW          = 32,
    parameter int unsigned   MEM_AW      = 10,
    parameter logic [AW-1:0] BASE_ADDR   = '0,
    parameter int unsigned   WAIT_CYCLES = 2,
    parameter int unsigned   RTY_EVERY   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   data_i,
    output logic [DW-1:0]   data_o,
    input  logic [DW/8-1:0] sel_i,
    input  logic            we_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    output logic            ack_o,
    output logic            err_o,
    output logic            rty_o
);

    localparam int unsigned SW    = DW / 8;
    localparam int unsigned Depth = 2 ** MEM_AW;
    localparam logic [3:0]  WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
    typedef enum logic [1:0] {KindAck, KindErr, KindRty} kind_e;

    logic [DW-1:0] mem [Depth];

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [MEM_AW-1:0] idx_q, idx_d;
    logic              we_q, we_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic req;
    logic addr_err;
    logic rty_hit;
    logic resp_live;
    logic mem_wr;

    assign req      = cyc_i & stb_i;
    assign addr_err = (addr_i[AW-1:MEM_AW+2] != BASE_ADDR[AW-1:MEM_AW+2]) ||
                      (addr_i[1:0] != 2'b00);

    // Terminations are qualified by the live request so a dropped strobe in RESP aborts cleanly.
    assign resp_live = (state_q == StResp) && req;
    assign mem_wr    = resp_live && (kind_q == KindAck) && we_q;
    assign ack_o     = resp_live && (kind_q == KindAck);
    assign err_o     = resp_live && (kind_q == KindErr);
    assign data_o    = rdata_q;

`ifdef WB_SLAVE_MEM_RTY_EN
    localparam logic [3:0] RtyLast = 4'(RTY_EVERY - 1);

    logic [3:0] rcnt_q;
    logic       cnt_adv;

    assign cnt_adv = resp_live && (kind_q != KindErr);
    assign rty_hit = (RTY_EVERY != 0) && (rcnt_q == RtyLast);
    assign rty_o   = resp_live && (kind_q == KindRty);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rcnt_q <= 4'd0;
        end else if (cnt_adv) begin
            rcnt_q <= (kind_q == KindRty) ? 4'd0 : rcnt_q + 4'd1;
        end
    end
`else
    logic unused_rty_cfg;

    assign unused_rty_cfg = (RTY_EVERY != 0);
    assign rty_hit        = 1'b0;
    assign rty_o          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d   = addr_i[MEM_AW+1:2];
                    we_d    = we_i;
                    sel_d   = sel_i;
                    wdata_d = data_i;
                    if (addr_err) begin
                        kind_d = KindErr;
                    end else if (rty_hit) begin
                        kind_d = KindRty;
                    end else begin
                        kind_d = KindAck;
                    end
                    if (WAIT_CYCLES > 0) begin
                        state_d = StWait;
                        wcnt_d  = WaitLoad;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (wcnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Read data is captured on entry to RESP; it holds afterwards except on err/rty.
        if ((state_d == StResp) && (state_q != StResp)) begin
            if (kind_d != KindAck) begin
                rdata_d = '0;
            end else if (!we_d) begin
                rdata_d = mem[idx_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            kind_q  <= KindAck;
            wcnt_q  <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && mem_wr) begin
            for (int k = 0; k < SW; k++) begin
                if (sel_q[k]) begin
                    mem[idx_q][k*8 +: 8] <= wdata_q[k*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_mem.sv
// Self-checking bench for wb_slave_mem: scoreboarded transfers, err, abort, reset and retry.
module tb_wb_slave_mem;

    localparam int unsigned WAIT   = 2;
    localparam int unsigned REVERY = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;
    logic        rty;

    always #5 clk = ~clk;

    wb_slave_mem #(
        .DW          (32),
        .AW          (32),
        .MEM_AW      (10),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (WAIT),
        .RTY_EVERY   (REVERY)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .addr_i (addr),
        .data_i (wdat),
        .data_o (rdat),
        .sel_i  (sel),
        .we_i   (we),
        .cyc_i  (cyc),
        .stb_i  (stb),
        .ack_o  (ack),
        .err_o  (err),
        .rty_o  (rty)
    );

    // kind: 0 = ack, 1 = err, 2 = rty
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [0:1023];
    int          rcnt  = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic xfer(input string nm, input logic [31:0] a, input bit w,
                        input logic [31:0] d, input logic [3:0] s);
        exp_t        e;
        exp_t        g;
        int          k;
        int          got;
        int          obs;
        logic [31:0] word;
        e.name = nm;
        e.data = '0;
        e.chk  = 1'b1;
        if (a[31:12] != 20'd0 || a[1:0] != 2'd0) begin
            e.kind = 1;
        end
`ifdef WB_SLAVE_MEM_RTY_EN
        else if (rcnt == REVERY - 1) begin
            e.kind = 2;
            rcnt   = 0;
        end
`endif
        else begin
            e.kind = 0;
            rcnt   = (rcnt + 1) % 16;
            if (w) begin
                word = model[a[11:2]];
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) word[b*8 +: 8] = d[b*8 +: 8];
                end
                model[a[11:2]] = word;
                e.chk = 1'b0;
            end else begin
                e.data = model[a[11:2]];
            end
        end
        sb.push_back(e);

        @(negedge clk);
        addr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        got = 0;
        k   = 0;
        while (got == 0 && k < 20) begin
            @(negedge clk);
            k++;
            if (ack | err | rty) got = k;
        end
        g = sb.pop_front();
        n_cmp++;
        if (got == 0) begin
            n_bad++;
            $display("FAIL %s timeout: no termination in 20 cycles, required one after %0d",
                     g.name, WAIT + 1);
        end else begin
            obs = ack ? 0 : (err ? 1 : 2);
            n_cmp++;
            if (obs !== g.kind) begin
                n_bad++;
                $display("FAIL %s kind: got %0d required %0d (0=ack 1=err 2=rty)",
                         g.name, obs, g.kind);
            end
            n_cmp++;
            if (got !== WAIT + 1) begin
                n_bad++;
                $display("FAIL %s latency: got %0d required %0d", g.name, got, WAIT + 1);
            end
            n_cmp++;
            if ($countones({ack, err, rty}) !== 1) begin
                n_bad++;
                $display("FAIL %s exclusive: ack/err/rty=%b%b%b required one-hot",
                         g.name, ack, err, rty);
            end
            if (g.chk) begin
                n_cmp++;
                if (rdat !== g.data) begin
                    n_bad++;
                    $display("FAIL %s data: got %h required %h", g.name, rdat, g.data);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc = 1'b0;
        stb = 1'b0;
    endtask

    task automatic check_idle(input string nm, input logic [31:0] dexp);
        n_cmp++;
        if ({ack, err, rty} !== 3'b000) begin
            n_bad++;
            $display("FAIL %s terms: ack/err/rty=%b%b%b required 000", nm, ack, err, rty);
        end
        n_cmp++;
        if (rdat !== dexp) begin
            n_bad++;
            $display("FAIL %s data_o: got %h required %h", nm, rdat, dexp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdat = '0; sel = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset", 32'h0);
        rst_n = 1'b1;
        rcnt  = 0;
    endtask

    task automatic test_retry();
        xfer("pre_0c", 32'h0C, 1'b1, 32'h0C0C_0C0C, 4'hF);
        xfer("pre_1c", 32'h1C, 1'b1, 32'h1C1C_1C1C, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rcnt  = 0;
        for (int i = 0; i < 8; i++) begin
            xfer($sformatf("rwr%0d", i + 1), 32'(i * 4), 1'b1, 32'hA000_0000 + 32'(i), 4'hF);
        end
        xfer("rrd_0c", 32'h0C, 1'b0, 32'h0, 4'hF);
        xfer("rrd_1c", 32'h1C, 1'b0, 32'h0, 4'hF);
    endtask

    task automatic test_rw();
        xfer("wr_10", 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
        xfer("rd_10", 32'h10, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        check_idle("hold_10", model[4]);
    endtask

    task automatic test_byte_sel();
        xfer("wr_20", 32'h20, 1'b1, 32'h1122_3344, 4'hF);
        xfer("wr_20_sel", 32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101);
        xfer("rd_20", 32'h20, 1'b0, 32'h0, 4'hF);
    endtask

    task automatic test_err();
        xfer("rd_out", 32'h0000_1000, 1'b0, 32'h0, 4'hF);
        xfer("rd_mis", 32'h0000_0002, 1'b0, 32'h0, 4'hF);
        xfer("wr_mis", 32'h0000_0012, 1'b1, 32'hFFFF_FFFF, 4'hF);
        xfer("wr_out", 32'h0001_0010, 1'b1, 32'hFFFF_FFFF, 4'hF);
        xfer("rd_10b", 32'h10, 1'b0, 32'h0, 4'hF);
    endtask

    task automatic test_abort();
        xfer("wr_30", 32'h30, 1'b1, 32'h3030_3030, 4'hF);
        @(negedge clk);
        addr = 32'h30; we = 1'b1; wdat = 32'hBAD0_BAD0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ack, err, rty} !== 3'b000) begin
                n_bad++;
                $display("FAIL abort_term%0d: ack/err/rty=%b%b%b required 000", i, ack, err, rty);
            end
        end
        cyc = 1'b0;
        xfer("rd_30", 32'h30, 1'b0, 32'h0, 4'hF);
    endtask

    task automatic test_reset_mid();
        xfer("wr_40", 32'h40, 1'b1, 32'h4040_4040, 4'hF);
        @(negedge clk);
        addr = 32'h40; we = 1'b1; wdat = 32'h0BAD_BAD0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0;
        stb = 1'b0;
        check_idle("mid_reset", 32'h0);
        rst_n = 1'b1;
        rcnt  = 0;
        xfer("rd_40", 32'h40, 1'b0, 32'h0, 4'hF);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        test_reset();
        test_retry();
        test_rw();
        test_byte_sel();
        test_err();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
